// File: rtl/fir_pkg.sv
// fir_pkg: shared loader states, framing constants and FIR default geometry
package fir_pkg;
  typedef enum logic [2:0] {IDLE, QUIESCE, RX_LO, RX_HI, CK_LO, CK_HI} load_state_e;
  localparam int BYTES_PER_COEFF     = 2;
  localparam int CHECKSUM_BYTES      = 2;
  localparam int FIR_ORDER           = 50;
  localparam int FIR_TAP_DATA_WIDTH  = 16;
  localparam int FIR_TAP_ADDR_WIDTH  = 6;
  localparam int LOAD_TIMEOUT_CYCLES = 1024;
  localparam int LOAD_TMO_WIDTH      = 11;
endpackage

// File: rtl/fir_load_timeout.sv
// fir_load_timeout: counts idle cycles between stream bytes and flags expiry
module fir_load_timeout
  import fir_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LOAD_TIMEOUT_CYCLES,
  parameter int TMO_WIDTH      = LOAD_TMO_WIDTH
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  logic [TMO_WIDTH-1:0] cnt_q, cnt_d;
  // expiry fires on the idle cycle that would bring the count to TIMEOUT_CYCLES
  always_comb begin
    cnt_d    = i_clear ? '0 : i_enable ? cnt_q + 1'b1 : cnt_q;
    o_expire = i_enable && !i_clear && (cnt_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1));
  end
  // idle-cycle counter
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams bytes into FIR taps 0..ORDER, verifies checksum, owns the filter enable
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int ORDER          = FIR_ORDER,
  parameter int TAP_DATA_WIDTH = FIR_TAP_DATA_WIDTH,
  parameter int TAP_ADDR_WIDTH = FIR_TAP_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = LOAD_TIMEOUT_CYCLES,
  parameter int TMO_WIDTH      = LOAD_TMO_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_load_start,
  input  logic                      i_run_req,
  input  logic                      i_byte_valid,
  input  logic [7:0]                i_byte_data,
  output logic                      o_byte_ready,
  output logic                      o_fir_en,
  output logic                      o_tap_wr_en,
  output logic [TAP_ADDR_WIDTH-1:0] o_tap_wr_addr,
  output logic [TAP_DATA_WIDTH-1:0] o_tap_wr_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);
  load_state_e               state_q, state_d;
  logic [TAP_ADDR_WIDTH-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [TAP_DATA_WIDTH-1:0] sum_q, sum_d, wr_data_q, wr_data_d, word;
  logic [7:0]                lo_q, lo_d;
  logic                      ready_q, ready_d, fir_en_q, fir_en_d, wr_en_q, wr_en_d;
  logic                      busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                      xfer, tmo_clear, tmo_expire;

  assign xfer      = i_byte_valid && ready_q;
  assign word      = {i_byte_data, lo_q};
  assign tmo_clear = xfer || (state_q == IDLE && i_load_start);

  fir_load_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMO_WIDTH     (TMO_WIDTH)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (tmo_clear),
    .i_enable(ready_q && !xfer),
    .o_expire(tmo_expire)
  );

  // next-state, word assembly, checksum and registered-output computation
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sum_d     = sum_q;
    lo_d      = lo_q;
    err_d     = err_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: if (i_load_start) begin
        state_d = QUIESCE;
        err_d   = 1'b0;
        addr_d  = '0;
        sum_d   = '0;
      end
      QUIESCE: state_d = RX_LO;
      RX_LO: if (xfer) begin
        lo_d    = i_byte_data;
        state_d = RX_HI;
      end
      RX_HI: if (xfer) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = word;
        sum_d     = sum_q + word;
        if (addr_q == TAP_ADDR_WIDTH'(ORDER)) state_d = CK_LO;
        else begin
          addr_d  = addr_q + 1'b1;
          state_d = RX_LO;
        end
      end
      CK_LO: if (xfer) begin
        lo_d    = i_byte_data;
        state_d = CK_HI;
      end
      CK_HI: if (xfer) begin
        state_d = IDLE;
        done_d  = (word == sum_q);
        err_d   = (word != sum_q);
      end
      default: state_d = IDLE;
    endcase
    if (tmo_expire) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
    ready_d  = state_d inside {RX_LO, RX_HI, CK_LO, CK_HI};
    busy_d   = state_d != IDLE;
    fir_en_d = i_run_req && state_q == IDLE && !err_q && !i_load_start;
  end

  // state and output registers
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sum_q     <= '0;
      lo_q      <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      fir_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sum_q     <= sum_d;
      lo_q      <= lo_d;
      err_q     <= err_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      fir_en_q  <= fir_en_d;
    end

  assign o_byte_ready  = ready_q;
  assign o_fir_en      = fir_en_q;
  assign o_tap_wr_en   = wr_en_q;
  assign o_tap_wr_addr = wr_addr_q;
  assign o_tap_wr_data = wr_data_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: directed checks of the coefficient loader (ORDER=3 and default ORDER=50)
module tb_fir_coeff_loader;
  logic       clk = 0, rst_n = 0, load_start = 0, b_load_start = 0, run_req = 0, bv = 0;
  logic [7:0] bd = 0;
  logic       ready, fir_en, wr_en, busy, done, err;
  logic [5:0] wr_addr;
  logic [15:0] wr_data;
  logic       b_ready, b_fir_en, b_wr_en, b_busy, b_done, b_err;
  logic [5:0] b_wr_addr;
  logic [15:0] b_wr_data;
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [5:0]  wa[$], b_wa[$];
  logic [15:0] wd[$], b_wd[$];
  int n_done = 0, b_n_done = 0, n_en_bad = 0;
  logic [7:0]  good [10] = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'h34, 8'h12, 8'h00, 8'h80, 8'h34, 8'h92};
  logic [15:0] exp_w [4] = '{16'h0001, 16'hFFFF, 16'h1234, 16'h8000};
  logic [15:0] big_w [51];
  logic [15:0] big_sum;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_coeff_loader #(.ORDER(3), .TIMEOUT_CYCLES(8), .TMO_WIDTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(load_start), .i_run_req(run_req),
    .i_byte_valid(bv), .i_byte_data(bd), .o_byte_ready(ready), .o_fir_en(fir_en),
    .o_tap_wr_en(wr_en), .o_tap_wr_addr(wr_addr), .o_tap_wr_data(wr_data),
    .o_busy(busy), .o_done(done), .o_err(err));

  fir_coeff_loader dut50 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(b_load_start), .i_run_req(run_req),
    .i_byte_valid(bv), .i_byte_data(bd), .o_byte_ready(b_ready), .o_fir_en(b_fir_en),
    .o_tap_wr_en(b_wr_en), .o_tap_wr_addr(b_wr_addr), .o_tap_wr_data(b_wr_data),
    .o_busy(b_busy), .o_done(b_done), .o_err(b_err));

  // record strobes, done pulses and any enable seen during a load
  always @(negedge clk) begin
    if (wr_en) begin wa.push_back(wr_addr); wd.push_back(wr_data); end
    if (done) n_done++;
    if (busy && fir_en) n_en_bad++;
    if (b_wr_en) begin b_wa.push_back(b_wr_addr); b_wd.push_back(b_wr_data); end
    if (b_done) b_n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic clear_mon();
    wa.delete(); wd.delete(); n_done = 0; n_en_bad = 0;
  endtask

  task automatic start(input bit big);
    if (big) b_load_start = 1; else load_start = 1;
    @(posedge clk); #1;
    load_start = 0; b_load_start = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit big);
    int n = 0;
    bv = 1; bd = b;
    do begin @(negedge clk); n++; end while (!(big ? b_ready : ready) && n < 40);
    if (!(big ? b_ready : ready)) begin
      check("ready_wait", 0, 1);
      bv = 0;
      return;
    end
    @(posedge clk); #1;
    bv = 0;
  endtask

  task automatic gap(input int g);
    repeat (g) begin @(posedge clk); #1; end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wa.size(), 4);
    for (int i = 0; i < wa.size() && i < 4; i++) begin
      check({tag, "_addr"}, wa[i], i);
      check({tag, "_data"}, wd[i], exp_w[i]);
    end
  endtask

  initial begin
    int t0, cnt;
    // reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_fir_en", fir_en, 0);
    check("rst_wr", {wr_en, wr_addr, wr_data}, 0);
    check("rst_done_err", {done, err}, 0);
    @(negedge clk); rst_n = 1; run_req = 1;
    @(posedge clk); #1;
    gap(2);
    @(negedge clk);
    check("idle_fir_en", fir_en, 1);
    @(posedge clk); #1;

    // back-to-back good load
    clear_mon();
    start(0);
    @(negedge clk);
    check("start_fir_en", fir_en, 0);
    check("start_busy", busy, 1);
    @(posedge clk); #1;
    foreach (good[i]) send(good[i], 0);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_fir_en_lag", fir_en, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("fir_en_back", fir_en, 1);
    check_writes("b2b");
    check("b2b_ndone", n_done, 1);
    check("b2b_err", err, 0);
    check("b2b_en_in_load", n_en_bad, 0);
    @(posedge clk); #1;

    // bad checksum
    clear_mon();
    start(0);
    for (int i = 0; i < 8; i++) send(good[i], 0);
    send(8'h35, 0); send(8'h92, 0);
    gap(1);
    check_writes("bad");
    check("bad_err", err, 1);
    check("bad_ndone", n_done, 0);
    cnt = 0;
    repeat (6) begin @(negedge clk); cnt += fir_en; end
    check("bad_fir_en_held", cnt, 0);
    @(posedge clk); #1;

    // restart clears error; this load uses random gaps
    clear_mon();
    start(0);
    @(negedge clk);
    check("restart_err_clr", err, 0);
    @(posedge clk); #1;
    foreach (good[i]) begin gap($urandom_range(0, 5)); send(good[i], 0); end
    gap(2);
    check_writes("gaps");
    check("gaps_ndone", n_done, 1);
    check("gaps_err", err, 0);

    // timeout after byte 3
    clear_mon();
    start(0);
    send(8'h01, 0); send(8'h00, 0); send(8'hFF, 0);
    gap(12);
    check("tmo_err", err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_nwr", wa.size(), 1);
    if (wa.size() > 0) check("tmo_wr", {wa[0], wd[0]}, {6'd0, 16'h0001});
    check("tmo_ndone", n_done, 0);

    // bytes in IDLE are ignored
    clear_mon();
    bv = 1; bd = 8'hA5; cnt = 0;
    repeat (6) begin @(negedge clk); cnt += ready; end
    @(posedge clk); #1; bv = 0;
    check("idle_ready", cnt, 0);
    check("idle_nwr", wa.size(), 0);
    check("idle_busy", busy, 0);

    // load_start mid-load is ignored
    clear_mon();
    start(0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 6) start(0);
      send(good[i], 0);
    end
    gap(2);
    check_writes("midstart");
    check("midstart_ndone", n_done, 1);
    check("midstart_err", err, 0);

    // asynchronous reset mid-load
    clear_mon();
    start(0);
    for (int i = 0; i < 5; i++) send(good[i], 0);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    check("arst_busy_ready", {busy, ready}, 0);
    check("arst_wr", {wr_en, wr_addr, wr_data}, 0);
    check("arst_en_done_err", {fir_en, done, err}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    clear_mon();
    start(0);
    foreach (good[i]) send(good[i], 0);
    gap(2);
    check_writes("post_rst");
    check("post_rst_ndone", n_done, 1);

    // default ORDER=50 full load
    big_sum = 0;
    for (int i = 0; i < 51; i++) begin
      big_w[i] = 16'(i * 16'h0E3B + 16'h1F01);
      big_sum += big_w[i];
    end
    start(1);
    t0 = cyc;
    for (int i = 0; i < 51; i++) begin send(big_w[i][7:0], 1); send(big_w[i][15:8], 1); end
    send(big_sum[7:0], 1); send(big_sum[15:8], 1);
    check("big_cycles", cyc - t0, 105);
    gap(2);
    check("big_nwr", b_wa.size(), 51);
    if (b_wa.size() == 51) begin
      check("big_addr50", b_wa[50], 50);
      check("big_data50", b_wd[50], big_w[50]);
      check("big_data17", b_wd[17], big_w[17]);
    end
    check("big_ndone", b_n_done, 1);
    check("big_err", b_err, 0);
    check("big_fir_en", b_fir_en, 1);
    check("small_idle_nwr", wa.size(), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
